mem_access: RTL

- Memory/IO access stage of the 8-bit RISC datapath. Sits directly upstream of the write-back stage.
- On the T2 phase pulse it decodes IR and performs the data-memory or port transfer for LDA, STA, IN and OUT over a req/ready bus.
- It produces Rtemp, the loaded byte that write-back consumes at T3.
- It asserts stall while a transfer is outstanding, so the timing generator holds T3 off until the transfer finishes.

---
 rtl/mem_access.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory/IO access stage: on T2 decodes LDA/STA/IN/OUT and runs one req/ready
// bus transfer, producing Rtemp for write-back and stalling T3 while busy.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        T2,
  input  logic [15:0] IR,
  input  logic [15:0] Addr,
  input  logic [7:0]  ALUOUT,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ready,
  output logic [7:0]  Rtemp,
  output logic        stall,
  output logic        done,
  output logic        bus_err
);

  // Handshake: in BUS, bus_req stays high with address/data held until the
  // edge at which bus_ready is sampled high; that edge completes the transfer.
  localparam logic [4:0] OP_STA = 5'b00100;
  localparam logic [4:0] OP_LDA = 5'b00101;
  localparam logic [4:0] OP_IN  = 5'b01000;
  localparam logic [4:0] OP_OUT = 5'b01001;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             io_q, io_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rtemp_q, rtemp_d;
  logic             err_q, err_d;

  logic [4:0] opcode;
  logic       is_mem, is_wr, is_io;

  assign opcode = IR[15:11];
  assign is_wr  = (opcode == OP_STA) || (opcode == OP_OUT);
  assign is_io  = (opcode == OP_IN)  || (opcode == OP_OUT);
  assign is_mem = is_wr || is_io || (opcode == OP_LDA);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    io_d    = io_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rtemp_d = rtemp_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (T2) begin
          we_d    = is_wr;
          io_d    = is_io;
          addr_d  = is_io ? {8'h00, IR[7:0]} : Addr;
          wdata_d = ALUOUT;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = is_mem ? S_BUS : S_DONE;
        end
      end
      S_BUS: begin
        // Ready is checked first so a completion on the last wait cycle is not an error.
        if (bus_ready) begin
          if (!we_q) rtemp_d = bus_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
          if (!we_q) rtemp_d = 8'hFF;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      rtemp_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      io_q    <= io_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rtemp_q <= rtemp_d;
      err_q   <= err_d;
    end
  end

  assign bus_req   = (state_q == S_BUS);
  assign stall     = (state_q == S_BUS);
  assign done      = (state_q == S_DONE);
  assign bus_we    = we_q;
  assign bus_io    = io_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign Rtemp     = rtemp_q;
  assign bus_err   = err_q;

endmodule
